// File: rtl/gpio_rb_pkg.sv
// Shared definitions for the GPIO readback scheduler.
// Contents: source encodings, AUTO select code, FSM state type, ADC beat constants.
package gpio_rb_pkg;

  // Source indices. These values also appear on rd_src.
  localparam logic [1:0] SRC_A   = 2'd0;
  localparam logic [1:0] SRC_C   = 2'd1;
  localparam logic [1:0] SRC_MAC = 2'd2;
  localparam logic [1:0] SRC_NL  = 2'd3;

  localparam logic [2:0] SEL_AUTO = 3'd4;

  localparam int unsigned BEATS_PER_ADC = 4;
  localparam int unsigned BEAT_CNT_W    = $clog2(BEATS_PER_ADC);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHold
  } state_e;

endpackage

// File: rtl/gpio_rb_rr_pick.sv
// Combinational 4-way rotating-priority picker.
// Ports:
//   valid  in  4  per-source valid
//   rr_ptr in  2  last granted source; scan starts at rr_ptr+1
//   hit    out 1  at least one source valid
//   idx    out 2  first valid source in scan order
module gpio_rb_rr_pick
  import gpio_rb_pkg::*;
(
  input  logic [3:0] valid,
  input  logic [1:0] rr_ptr,
  output logic       hit,
  output logic [1:0] idx
);

  logic [1:0] cand;

  always_comb begin
    hit  = 1'b0;
    idx  = 2'd0;
    cand = 2'd0;
    // Offset 4 wraps to rr_ptr itself, so the last-granted source has lowest priority.
    for (int k = 1; k <= 4; k++) begin
      cand = rr_ptr + 2'(k);
      if (!hit && valid[cand]) begin
        hit = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/gpio_readback_sched.sv
// Sequences CPU readback of four stream sources over the GPIO bridge.
// A four-phase request (req level) selects a source or AUTO round-robin; one 32-bit
// beat is drained per request (128-bit ADC words are split into 4 beats, low beat
// first) and held on rd_* until req drops. FETCH times out with rd_err.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req, sel, cnt_clr        CPU request level, source select, ADC beat counter clear
//   rd_data/valid/err/src    captured beat and status
//   a_*, c_*                 narrow (NUM_BITS) stream sources
//   mac_*, nl_*              128-bit ADC stream sources
module gpio_readback_sched
  import gpio_rb_pkg::*;
#(
  parameter int unsigned NUM_BITS = 16,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic [2:0]          sel,
  input  logic                cnt_clr,
  output logic [31:0]         rd_data,
  output logic                rd_valid,
  output logic                rd_err,
  output logic [1:0]          rd_src,
  input  logic [NUM_BITS-1:0] a_data,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [NUM_BITS-1:0] c_data,
  input  logic                c_valid,
  output logic                c_ready,
  input  logic [127:0]        mac_data,
  input  logic                mac_valid,
  output logic                mac_ready,
  input  logic [127:0]        nl_data,
  input  logic                nl_valid,
  output logic                nl_ready
);

  localparam int unsigned TW = $clog2(TIMEOUT);

  state_e                state_q, state_d;
  logic [2:0]            sel_q, sel_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [1:0]            rr_q, rr_d;
  logic [BEAT_CNT_W-1:0] mac_cnt_q, mac_cnt_d, nl_cnt_q, nl_cnt_d;
  logic                  req_q;
  logic [31:0]           rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d, rd_err_q, rd_err_d;
  logic [1:0]            rd_src_q, rd_src_d;

  logic [3:0]  valid_vec;
  logic        pick_hit, hit, fetch_hit, rise, is_auto;
  logic [1:0]  pick_idx, idx;
  logic [31:0] beat;

  assign valid_vec = {nl_valid, mac_valid, c_valid, a_valid};
  assign rise      = req & ~req_q;
  assign is_auto   = (sel_q == SEL_AUTO);

  gpio_rb_rr_pick u_pick (
    .valid  (valid_vec),
    .rr_ptr (rr_q),
    .hit    (pick_hit),
    .idx    (pick_idx)
  );

  always_comb begin
    idx       = is_auto ? pick_idx : sel_q[1:0];
    hit       = is_auto ? pick_hit : valid_vec[idx];
    // An abort (req low) wins over a hit, so it also gates the readies.
    fetch_hit = (state_q == StFetch) && req && hit;
    unique case (idx)
      SRC_A:   beat = 32'(a_data);
      SRC_C:   beat = 32'(c_data);
      SRC_MAC: beat = mac_data[{mac_cnt_q, 5'd0} +: 32];
      default: beat = nl_data[{nl_cnt_q, 5'd0} +: 32];
    endcase
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    timer_d    = timer_q;
    rr_d       = rr_q;
    mac_cnt_d  = mac_cnt_q;
    nl_cnt_d   = nl_cnt_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    rd_err_d   = rd_err_q;
    rd_src_d   = rd_src_q;
    a_ready    = fetch_hit && (idx == SRC_A);
    c_ready    = fetch_hit && (idx == SRC_C);
    // ADC words pop only on their last beat.
    mac_ready  = fetch_hit && (idx == SRC_MAC) && (mac_cnt_q == BEAT_CNT_W'(BEATS_PER_ADC - 1));
    nl_ready   = fetch_hit && (idx == SRC_NL) && (nl_cnt_q == BEAT_CNT_W'(BEATS_PER_ADC - 1));

    unique case (state_q)
      StIdle: begin
        if (cnt_clr) begin
          mac_cnt_d = '0;
          nl_cnt_d  = '0;
        end
        if (rise) begin
          if (sel <= SEL_AUTO) begin
            sel_d   = sel;
            timer_d = '0;
            state_d = StFetch;
          end else begin
            rd_err_d   = 1'b1;
            rd_valid_d = 1'b1;
            rd_data_d  = '0;
            state_d    = StHold;
          end
        end
      end
      StFetch: begin
        if (!req) begin
          state_d = StIdle;
        end else if (hit) begin
          rd_data_d  = beat;
          rd_src_d   = idx;
          rd_valid_d = 1'b1;
          state_d    = StHold;
          if (is_auto) rr_d = idx;
          if (idx == SRC_MAC) mac_cnt_d = mac_cnt_q + 1'b1;
          if (idx == SRC_NL)  nl_cnt_d  = nl_cnt_q + 1'b1;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          rd_err_d   = 1'b1;
          rd_valid_d = 1'b1;
          rd_data_d  = '0;
          state_d    = StHold;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StHold: begin
        if (!req) begin
          rd_valid_d = 1'b0;
          rd_err_d   = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      timer_q    <= '0;
      rr_q       <= 2'd3;
      mac_cnt_q  <= '0;
      nl_cnt_q   <= '0;
      req_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_src_q   <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      timer_q    <= timer_d;
      rr_q       <= rr_d;
      mac_cnt_q  <= mac_cnt_d;
      nl_cnt_q   <= nl_cnt_d;
      req_q      <= req;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      rd_src_q   <= rd_src_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_err   = rd_err_q;
  assign rd_src   = rd_src_q;

endmodule
